serial_bit_deser: RTL
=====================

Name: serial_bit_deser

Overview:
- Serial-in, parallel-out deserializer; the receive end of the team's bit-order-reversing serial path.
- Accepts one bit per handshake and assembles WIDTH-bit words in either bit order. LSB_FIRST undoes an LSB-first transmit; MSB_FIRST reception of the same stream yields the bit-reversed word.
- One word of output buffering plus the shift register, with valid/ready handshakes on both sides.
- Sits between a serial link front-end and byte-wide datapath logic.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- LSB_FIRST, 1, 1: k-th accepted bit lands at m_data[k]; 0: lands at m_data[WIDTH-1-k].

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  serial bit valid.
- s_bit  input  1  serial data bit.
- s_sof  input  1  start-of-word marker, qualified by s_valid.
- s_ready  output  1  deserializer can accept a bit this cycle.
- m_valid  output  1  m_data holds a complete word.
- m_data  output  WIDTH  assembled word.
- m_ready  input  1  consumer accepts word.
- err_frame  output  1  one-cycle pulse: partial word discarded on s_sof.
- frame_err_cnt  output  8  saturating count of err_frame events.

Behaviour:
- Bit accept: s_valid && s_ready at a rising edge. Word accept: m_valid && m_ready.
- Reset (asynchronous assert, synchronous to clk on release):
  - bit count = 0, shift reg = 0, state = EMPTY.
  - m_valid = 0, m_data = 0, err_frame = 0, frame_err_cnt = 0.
  - s_ready = 1 while in reset and after release.
- States:
  - EMPTY: count = 0.
  - SHIFT: 0 < count < WIDTH.
  - FULL: WIDTH bits held, waiting for the output register.
- s_ready = (state != FULL). Combinational from state only; no path from m_ready.
- Bit placement: bit k (0-based within the word) is written to index k if LSB_FIRST=1, else to index WIDTH-1-k. Unwritten positions hold 0 and are cleared at word start.
- Completion: the WIDTH-th bit is accepted at edge t.
  - If the output register is free at edge t (m_valid=0, or a word accept occurs at t), the word loads into m_data at edge t+1. m_valid=1 from t+1. count returns to 0 and state goes to EMPTY.
  - Otherwise state goes to FULL and s_ready=0. The word transfers to m_data on the edge after the first word accept. m_valid stays 1 continuously with no bubble, and state returns to EMPTY.
- Latency: last bit accepted to m_valid is 1 cycle when the output register is free. Sustained throughput is 1 bit/cycle with m_ready held high.
- m_data and m_valid hold stable while m_valid=1 and m_ready=0. m_valid drops on the edge after the word accept unless a new word loads on that same edge.
- s_sof:
  - s_sof=1 on an accepted bit with count=0: normal start, no error.
  - s_sof=1 on an accepted bit with count>0: discard the partial word. That bit becomes bit 0 of a new word (count=1). err_frame=1 for the following cycle. frame_err_cnt increments, saturating at 255.
  - s_sof ignored when not accepted.
  - s_sof is optional: a bit accepted at count=0 without s_sof starts a word.
- No bit is ever dropped or overwritten while s_ready=0. s_bit and s_sof are don't-care when s_valid=0.
- Reset mid-word or in FULL: partial or held word is lost; no err_frame is raised.

Test Plan:
- LSB_FIRST=1, m_ready=1, bits 1,1,0,1,1,0,1,0 on consecutive cycles -> m_data=0x5B, m_valid one cycle after the 8th bit; no err_frame.
- LSB_FIRST=0, same bit sequence -> m_data=0xDA (bit reverse of 0x5B).
- Back-to-back streams 0x0F then 0x03 with m_ready=0 -> first word held, second assembles, state FULL, s_ready=0. Raise m_ready -> 0x0F accepted, 0x03 appears next cycle with m_valid continuous, then s_ready=1.
- 3 bits sent, then a bit with s_sof=1 followed by 7 bits of 0x7B -> err_frame pulses one cycle, frame_err_cnt=1, output 0x7B.
- 300 forced mid-word s_sof events -> frame_err_cnt saturates at 255.
- rst_n asserted asynchronously mid-word and while FULL -> m_valid=0, m_data=0, s_ready=1 immediately. The next 8 bits assemble cleanly into 0x43 (bits 1,1,0,0,0,0,1,0).

Source files
------------

// File: rtl/serial_bit_deser_if.sv
// rtl/serial_bit_deser_if.sv - serial bit input and parallel word output handshake bundle
interface serial_bit_deser_if #(
    parameter int WIDTH = 8
) ();
    logic             s_valid;
    logic             s_bit;
    logic             s_sof;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport slave (
        input  s_valid, s_bit, s_sof, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_bit, s_sof, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/serial_bit_deser.sv
// rtl/serial_bit_deser.sv - serial-in parallel-out deserializer with one word of output buffering
module serial_bit_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_bit_deser_if.slave   bus,
    output logic                err_frame,
    output logic [7:0]          frame_err_cnt
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_FULL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             bit_acc;
    logic             word_acc;
    logic             restart;
    logic             last_bit;
    logic             out_free;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word;

    // Ready depends only on state so the serial side never sees m_ready combinationally.
    assign bus.s_ready    = (state_q != ST_FULL);
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign err_frame      = err_q;
    assign frame_err_cnt  = cnt_q;

    // Next-state: place incoming bit, complete words, and hand them to the output register.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        bit_acc  = bus.s_valid && (state_q != ST_FULL);
        word_acc = valid_q && bus.m_ready;
        restart  = bit_acc && bus.s_sof && (count_q != '0);
        // A restart makes the current bit position 0 of a fresh word.
        pos      = restart ? '0 : count_q;
        idx      = LSB_FIRST ? pos : (CW'(WIDTH - 1) - pos);
        base     = (pos == '0) ? '0 : shift_q;
        word     = base | ({{(WIDTH-1){1'b0}}, bus.s_bit} << idx);
        last_bit = bit_acc && !restart && (count_q == CW'(WIDTH - 1));
        out_free = !valid_q || word_acc;

        if (word_acc) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_FULL: begin
                // Held word moves into the slot being vacated, keeping m_valid high.
                if (word_acc) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    shift_d = '0;
                    count_d = '0;
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                if (bit_acc) begin
                    if (restart) begin
                        err_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    if (last_bit) begin
                        if (out_free) begin
                            data_d  = word;
                            valid_d = 1'b1;
                            shift_d = '0;
                            count_d = '0;
                            state_d = ST_EMPTY;
                        end else begin
                            shift_d = word;
                            count_d = CW'(WIDTH);
                            state_d = ST_FULL;
                        end
                    end else begin
                        shift_d = word;
                        count_d = pos + 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
            end
        endcase
    end

    // State register; reset discards any partial or held word without flagging an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
